map_scroll_ctrl: RTL and testbench

//  Generates shift_map, the horizontal map-scroll offset consumed by mario_movement.

---
 rtl/map_scroll_ctrl_pkg.sv | 25 ++
 rtl/map_scroll_ctrl_step_timer.sv | 32 +++
 rtl/map_scroll_ctrl.sv | 142 ++++++++++++++
 tb/tb_map_scroll_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/map_scroll_ctrl_pkg.sv
// Shared game constants and scroll-controller types.
// Game-state encodings match the ones mario_movement uses.
package map_scroll_ctrl_pkg;

  localparam logic [1:0] GAME_END   = 2'd0;
  localparam logic [1:0] GAME_ING   = 2'd1;
  localparam logic [1:0] GAME_START = 2'd2;

  localparam int SCREEN_W  = 20;
  localparam int MAP_LEN   = 128;
  localparam int MAX_SHIFT = MAP_LEN - SCREEN_W;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SCROLL = 2'd1,
    S_WAIT   = 2'd2,
    S_END    = 2'd3
  } scroll_state_t;

  // Right-most visible map column for a given scroll offset.
  function automatic logic [6:0] col_of_shift(input logic [6:0] shift);
    return shift + 7'(SCREEN_W - 1);
  endfunction

endpackage

// File: rtl/map_scroll_ctrl_step_timer.sv
// Tick-qualified step counter: one step pulse every STEP_TICKS enabled ticks.
// The pulse is combinational so the caller can act on the same clock edge.
module scroll_step_timer #(
  parameter int STEP_TICKS = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic step
);

  localparam logic [2:0] LAST = 3'(STEP_TICKS - 1);

  logic [2:0] count;

  assign step = enable && (count == LAST);

  // Count enabled ticks; wrap to zero on the step tick or any clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 3'd0;
    end else if (step) begin
      count <= 3'd0;
    end else if (enable) begin
      count <= count + 3'd1;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/map_scroll_ctrl.sv
// Horizontal map-scroll controller: advances shift_map, requests newly exposed
// columns from the tile loader and flags goal arrival at the end of the map.
module map_scroll_ctrl
  import map_scroll_ctrl_pkg::*;
#(
  parameter int SCROLL_X   = 10,
  parameter int STEP_TICKS = 2,
  parameter int GOAL_X     = 18
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [1:0] game_state,
  input  logic       forward,
  input  logic       fmovable,
  input  logic [4:0] mario_x,
  output logic [7:0] shift_map,
  output logic       scrolling,
  output logic       col_req,
  output logic [6:0] col_idx,
  input  logic       col_ack,
  output logic       goal_reached
);

  scroll_state_t state, state_next;
  logic [7:0]    shift_next;
  logic          col_req_next;
  logic [6:0]    col_idx_next;
  logic          goal_next;

  logic game_ing, game_start;
  logic scroll_ok, goal_hit;
  logic timer_clear, timer_enable, step_pulse;

  assign game_ing   = (game_state == GAME_ING);
  assign game_start = (game_state == GAME_START);

  // col_req in the term keeps a pending column fetch from being overtaken.
  assign scroll_ok = game_ing && forward && fmovable
                  && (mario_x > 5'(SCROLL_X))
                  && !col_req
                  && (shift_map < 8'(MAX_SHIFT));

  assign goal_hit = (state != S_END)
                 && (shift_map == 8'(MAX_SHIFT))
                 && (mario_x >= 5'(GOAL_X))
                 && game_ing;

  assign timer_enable = tick && (state == S_SCROLL) && scroll_ok && !goal_hit;
  assign timer_clear  = (state != S_SCROLL) || !scroll_ok || game_start || goal_hit;

  scroll_step_timer #(
    .STEP_TICKS (STEP_TICKS)
  ) u_step_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .step   (step_pulse)
  );

  // Next-state and next-output logic; GAME_START beats goal, goal beats scrolling.
  always_comb begin
    state_next   = state;
    shift_next   = shift_map;
    col_req_next = col_req;
    col_idx_next = col_idx;
    goal_next    = goal_reached;

    if (game_start) begin
      state_next   = S_IDLE;
      shift_next   = 8'd0;
      col_req_next = 1'b0;
      col_idx_next = 7'd0;
      goal_next    = 1'b0;
    end else if (goal_hit) begin
      state_next   = S_END;
      col_req_next = 1'b0;
      goal_next    = 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (scroll_ok) begin
            state_next = S_SCROLL;
          end else begin
            state_next = S_IDLE;
          end
        end
        S_SCROLL: begin
          if (!scroll_ok) begin
            state_next = S_IDLE;
          end else if (step_pulse) begin
            state_next   = S_WAIT;
            shift_next   = shift_map + 8'd1;
            col_req_next = 1'b1;
            col_idx_next = col_of_shift(shift_next[6:0]);
          end else begin
            state_next = S_SCROLL;
          end
        end
        S_WAIT: begin
          // The handshake completes even under GAME_END.
          if (col_ack) begin
            state_next   = S_IDLE;
            col_req_next = 1'b0;
          end else begin
            state_next = S_WAIT;
          end
        end
        S_END: begin
          state_next   = S_END;
          col_req_next = 1'b0;
          goal_next    = 1'b1;
        end
        default: begin
          state_next   = S_IDLE;
          col_req_next = 1'b0;
        end
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      shift_map    <= 8'd0;
      scrolling    <= 1'b0;
      col_req      <= 1'b0;
      col_idx      <= 7'd0;
      goal_reached <= 1'b0;
    end else begin
      state        <= state_next;
      shift_map    <= shift_next;
      scrolling    <= (state_next == S_SCROLL);
      col_req      <= col_req_next;
      col_idx      <= col_idx_next;
      goal_reached <= goal_next;
    end
  end

endmodule

// File: tb/tb_map_scroll_ctrl.sv
// Directed self-checking bench for map_scroll_ctrl (STEP_TICKS=2).
// Inputs change 1 ns after the rising edge; outputs are checked there too.
module tb_map_scroll_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [1:0] game_state;
  logic       forward;
  logic       fmovable;
  logic [4:0] mario_x;
  logic [7:0] shift_map;
  logic       scrolling;
  logic       col_req;
  logic [6:0] col_idx;
  logic       col_ack;
  logic       goal_reached;

  int n_checks = 0;
  int n_errors = 0;

  map_scroll_ctrl #(
    .SCROLL_X   (10),
    .STEP_TICKS (2),
    .GOAL_X     (18)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .game_state   (game_state),
    .forward      (forward),
    .fmovable     (fmovable),
    .mario_x      (mario_x),
    .shift_map    (shift_map),
    .scrolling    (scrolling),
    .col_req      (col_req),
    .col_idx      (col_idx),
    .col_ack      (col_ack),
    .goal_reached (goal_reached)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    game_state = 2'd1;
    forward    = 1'b1;
    fmovable   = 1'b1;
    mario_x    = 5'd11;
    col_ack    = 1'b1;
    cyc(1'b0);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    int n;
    int dec;
    logic [7:0] prev;

    tick = 1'b0;
    do_reset();
    check("rst_shift", shift_map, 0);
    check("rst_req", col_req, 0);
    check("rst_idx", col_idx, 0);
    check("rst_goal", goal_reached, 0);
    check("rst_scrolling", scrolling, 0);

    // 1: basic scrolling, ack tied high
    cyc(1'b0);
    check("t1_enter_scroll", scrolling, 1);
    cyc(1'b1);
    check("t1_half_step", shift_map, 0);
    cyc(1'b1);
    check("t1_shift1", shift_map, 1);
    check("t1_req1", col_req, 1);
    check("t1_idx20", col_idx, 20);
    cyc(1'b0);
    check("t1_req1_drop", col_req, 0);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    check("t1_shift2", shift_map, 2);
    check("t1_req2", col_req, 1);
    check("t1_idx21", col_idx, 21);
    cyc(1'b0);
    check("t1_req2_drop", col_req, 0);
    check("t1_shift2_hold", shift_map, 2);

    // 2: Mario at the scroll line moves, map does not
    do_reset();
    mario_x = 5'd10;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1);
      if (col_req || scrolling) cnt++;
    end
    check("t2_no_req", cnt, 0);
    check("t2_shift0", shift_map, 0);

    // 3: stalled ack holds request stable
    do_reset();
    col_ack = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    check("t3_req", col_req, 1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      if (col_req !== 1'b1 || col_idx !== 7'd20 || shift_map !== 8'd1) cnt++;
    end
    check("t3_stable", cnt, 0);
    col_ack = 1'b1;
    cyc(1'b0);
    check("t3_req_drop", col_req, 0);
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    check("t3_resume_shift", shift_map, 2);
    check("t3_resume_idx", col_idx, 21);

    // 5: blocked mid-step discards the partial step
    do_reset();
    cyc(1'b0);
    cyc(1'b1);
    fmovable = 1'b0;
    cyc(1'b1);
    check("t5_blocked_shift", shift_map, 0);
    check("t5_blocked_idle", scrolling, 0);
    fmovable = 1'b1;
    cyc(1'b0);
    cyc(1'b1);
    check("t5_full_step_needed", shift_map, 0);
    cyc(1'b1);
    check("t5_step", shift_map, 1);

    // GAME_END: pending handshake still completes, then map frozen
    do_reset();
    col_ack = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    game_state = 2'd0;
    for (int i = 0; i < 3; i++) cyc(1'b1);
    check("end_req_held", col_req, 1);
    check("end_idx_held", col_idx, 20);
    col_ack = 1'b1;
    cyc(1'b0);
    check("end_req_done", col_req, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1);
    check("end_shift_frozen", shift_map, 1);
    check("end_not_scrolling", scrolling, 0);

    // 6: GAME_START during a request
    do_reset();
    col_ack = 1'b0;
    cyc(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    check("t6_req", col_req, 1);
    game_state = 2'd2;
    cyc(1'b0);
    check("t6_shift0", shift_map, 0);
    check("t6_req0", col_req, 0);
    check("t6_idx0", col_idx, 0);
    check("t6_goal0", goal_reached, 0);
    game_state = 2'd1;
    col_ack    = 1'b1;
    cyc(1'b0);
    check("t6_from_idle", scrolling, 1);

    // 4: run to the end of the map, saturate, then goal
    do_reset();
    n = 0;
    dec = 0;
    prev = 8'd0;
    while (shift_map != 8'd108 && n < 600) begin
      cyc(1'b1);
      n++;
      if (shift_map < prev) dec++;
      prev = shift_map;
    end
    check("t4_reach_max", shift_map, 108);
    check("t4_monotonic", dec, 0);
    check("t4_idx127", col_idx, 127);
    cyc(1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1);
      if (col_req || shift_map !== 8'd108) cnt++;
    end
    check("t4_saturated", cnt, 0);
    check("t4_no_goal_yet", goal_reached, 0);
    mario_x = 5'd18;
    cyc(1'b0);
    check("t4_goal", goal_reached, 1);
    for (int i = 0; i < 5; i++) cyc(1'b1);
    check("t4_goal_hold", goal_reached, 1);
    check("t4_shift_hold", shift_map, 108);
    game_state = 2'd2;
    cyc(1'b0);
    check("t4_goal_cleared", goal_reached, 0);

    // Goal takes priority over a pending request
    do_reset();
    mario_x = 5'd18;
    n = 0;
    while (shift_map != 8'd108 && n < 600) begin
      col_ack = (shift_map != 8'd108);
      cyc(1'b1);
      n++;
    end
    check("prio_reach_max", shift_map, 108);
    check("prio_req_pending", col_req, 1);
    col_ack = 1'b0;
    cyc(1'b0);
    check("prio_req_dropped", col_req, 0);
    check("prio_goal", goal_reached, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
